// File: rtl/cpu_pkg.sv
// Shared types and address-field helpers for the data cache and its controller.
package cpu_pkg;
  localparam int ADDR_W     = 8;
  localparam int TAG_W      = 3;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 2;
  localparam int BLOCK_W    = 32;
  localparam int NUM_BLOCKS = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, MEM_WB, MEM_RD, UPDATE} state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: combinational lookup, synchronous byte write,
// whole-line fill and valid/dirty clear on reset.
module dcache_array
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IDX_W-1:0]   i_idx,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [TAG_W-1:0]   o_tag,
  output logic [BLOCK_W-1:0] o_data,
  input  logic               i_wr_en,
  input  logic [OFF_W-1:0]   i_off,
  input  logic [7:0]         i_wbyte,
  input  logic               i_fill_en,
  input  logic [TAG_W-1:0]   i_fill_tag,
  input  logic [BLOCK_W-1:0] i_fill_data
);
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag/data contents are don't-care after reset, so they carry no reset term.
  always_ff @(posedge CLK) begin
    if (i_fill_en) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_wr_en) begin
      r_data[i_idx][{i_off, 3'b000} +: 8] <= i_wbyte;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller: hit detect,
// miss FSM (write-back, fetch, update) and memory/CPU output decode.
module dcache_ctrl
  import cpu_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    READ,
  input  logic                    WRITE,
  input  logic [ADDR_W-1:0]       ADDRESS,
  input  logic [7:0]              WRITEDATA,
  output logic [7:0]              READDATA,
  output logic                    BUSYWAIT,
  output logic                    MEM_READ,
  output logic                    MEM_WRITE,
  output logic [TAG_W+IDX_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0]      MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]      MEM_READDATA,
  input  logic                    MEM_BUSYWAIT
);
  state_t r_state, w_next;
  logic [BLOCK_W-1:0] r_fill;

  logic [TAG_W-1:0]   w_tag, w_line_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic               w_valid, w_dirty, w_hit, w_req, w_rd;
  logic [BLOCK_W-1:0] w_line_data;
  logic               w_wr_en, w_fill_en;

  assign w_tag = addr_tag(ADDRESS);
  assign w_idx = addr_idx(ADDRESS);
  assign w_off = addr_off(ADDRESS);
  assign w_req = READ | WRITE;
  // Simultaneous READ and WRITE resolves to a store.
  assign w_rd  = READ & ~WRITE;
  assign w_hit = w_valid && (w_line_tag == w_tag);

  dcache_array u_array (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_idx       (w_idx),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_line_tag),
    .o_data      (w_line_data),
    .i_wr_en     (w_wr_en),
    .i_off       (w_off),
    .i_wbyte     (WRITEDATA),
    .i_fill_en   (w_fill_en),
    .i_fill_tag  (w_tag),
    .i_fill_data (r_fill)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (r_state == MEM_RD && !MEM_BUSYWAIT) r_fill <= MEM_READDATA;
  end

  always_comb begin
    w_next        = r_state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = '0;
    w_wr_en       = 1'b0;
    w_fill_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            if (w_rd) READDATA = w_line_data[{w_off, 3'b000} +: 8];
            w_wr_en = WRITE;
          end else begin
            BUSYWAIT = 1'b1;
            w_next   = w_dirty ? MEM_WB : MEM_RD;
          end
        end
      end
      MEM_WB: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {w_line_tag, w_idx};
        MEM_WRITEDATA = w_line_data;
        if (!MEM_BUSYWAIT) w_next = MEM_RD;
      end
      MEM_RD: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {w_tag, w_idx};
        if (!MEM_BUSYWAIT) w_next = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT  = 1'b1;
        w_fill_en = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset overrides the current-state decode so nothing escapes in the reset cycle.
    if (RESET) begin
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_WRITEDATA = '0;
      w_wr_en       = 1'b0;
      w_fill_en     = 1'b0;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a latency-modelled block memory.
module tb_dcache_ctrl;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        READ = 1'b0, WRITE = 1'b0;
  logic [7:0]  ADDRESS = '0, WRITEDATA = '0;
  logic [7:0]  READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sb_q[$];
  logic [5:0]  rd_log[$];
  logic [5:0]  wb_addr_log[$];
  logic [31:0] wb_data_log[$];
  int          both_cnt  = 0;
  int          stray_wd  = 0;
  logic        p_rd = 1'b0, p_wr = 1'b0;

  logic [31:0] mem [64];
  logic        mem_loaded = 1'b0;
  int          mcnt = 0;

  dcache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_init(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 1) return 32'h44332211;
    return {8'hA0 + b, 8'hB0 ^ b, 8'(i * 7), b};
  endfunction

  // Memory: busy for 4 cycles after a strobe rises, completes on the 5th.
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt < 4);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= mem_init(i);
      mem_loaded <= 1'b1;
    end else if (MEM_READ | MEM_WRITE) begin
      if (mcnt < 4) mcnt <= mcnt + 1;
      else begin
        mcnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end
    end else begin
      mcnt <= 0;
    end
  end

  always @(negedge CLK) begin
    if (MEM_READ && !p_rd) rd_log.push_back(MEM_ADDRESS);
    if (MEM_WRITE && !p_wr) begin
      wb_addr_log.push_back(MEM_ADDRESS);
      wb_data_log.push_back(MEM_WRITEDATA);
    end
    if (MEM_READ && MEM_WRITE) both_cnt++;
    if (!MEM_WRITE && MEM_WRITEDATA != 32'h0) stray_wd++;
    p_rd = MEM_READ;
    p_wr = MEM_WRITE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that retires the request.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output int cyc);
    bit done;
    logic [7:0] exp;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    cyc = 0; done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1;
      else cyc++;
    end
    if (!done) check("busywait_timeout", 32'd1, 32'd0);
    if (rd) begin
      exp = sb_q.pop_front();
      check("readdata", 32'(READDATA), 32'(exp));
    end
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rb, wb;
    logic [31:0] m;

    // Reset with a live request: outputs must stay quiet.
    READ = 1'b1; ADDRESS = 8'h05;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;
    @(posedge CLK); #1;

    // 1: clean miss on 0x05, then hit.
    rb = rd_log.size(); wb = wb_addr_log.size();
    sb_q.push_back(8'h22);
    access(1'b1, 1'b0, 8'h05, 8'h00, cyc);
    check("s1_miss_cycles", 32'(cyc), 32'd7);
    check("s1_rd_count", 32'(rd_log.size() - rb), 32'd1);
    if (rd_log.size() > rb) check("s1_rd_addr", 32'(rd_log[rb]), 32'h01);
    check("s1_no_wb", 32'(wb_addr_log.size() - wb), 32'd0);
    sb_q.push_back(8'h22);
    access(1'b1, 1'b0, 8'h05, 8'h00, cyc);
    check("s1_hit_cycles", 32'(cyc), 32'd0);

    // 2: write hit then read-back.
    rb = rd_log.size(); wb = wb_addr_log.size();
    access(1'b0, 1'b1, 8'h06, 8'hAB, cyc);
    check("s2_wr_hit_cycles", 32'(cyc), 32'd0);
    sb_q.push_back(8'hAB);
    access(1'b1, 1'b0, 8'h06, 8'h00, cyc);
    check("s2_rd_hit_cycles", 32'(cyc), 32'd0);
    check("s2_no_strobes", 32'((rd_log.size() - rb) + (wb_addr_log.size() - wb)), 32'd0);

    // 3: dirty conflict on index 1.
    rb = rd_log.size(); wb = wb_addr_log.size();
    m = mem_init(9);
    sb_q.push_back(m[23:16]);
    access(1'b1, 1'b0, 8'h26, 8'h00, cyc);
    check("s3_miss_cycles", 32'(cyc), 32'd12);
    check("s3_wb_count", 32'(wb_addr_log.size() - wb), 32'd1);
    if (wb_addr_log.size() > wb) begin
      check("s3_wb_addr", 32'(wb_addr_log[wb]), 32'h01);
      check("s3_wb_data", wb_data_log[wb], 32'h44AB2211);
    end
    check("s3_rd_count", 32'(rd_log.size() - rb), 32'd1);
    if (rd_log.size() > rb) check("s3_rd_addr", 32'(rd_log[rb]), 32'h09);

    // 4: write-allocate on a cold line, then evict it to prove it is dirty.
    rb = rd_log.size(); wb = wb_addr_log.size();
    access(1'b0, 1'b1, 8'h1C, 8'h7F, cyc);
    check("s4_miss_cycles", 32'(cyc), 32'd7);
    check("s4_no_wb", 32'(wb_addr_log.size() - wb), 32'd0);
    if (rd_log.size() > rb) check("s4_rd_addr", 32'(rd_log[rb]), 32'h07);
    else check("s4_rd_count", 32'(rd_log.size() - rb), 32'd1);
    wb = wb_addr_log.size();
    m = mem_init(63);
    sb_q.push_back(m[7:0]);
    access(1'b1, 1'b0, 8'hFC, 8'h00, cyc);
    check("s4_evict_cycles", 32'(cyc), 32'd12);
    m = mem_init(7);
    if (wb_addr_log.size() > wb) begin
      check("s4_wb_addr", 32'(wb_addr_log[wb]), 32'h07);
      check("s4_wb_data", wb_data_log[wb], {m[31:8], 8'h7F});
    end else check("s4_wb_count", 32'(wb_addr_log.size() - wb), 32'd1);

    // 5: reset in the second MEM_RD cycle.
    READ = 1'b1; ADDRESS = 8'h05;
    @(negedge CLK);
    check("s5_detect_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("s5_rst_mem_read", 32'(MEM_READ), 32'd0);
    check("s5_rst_busywait", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;
    @(negedge CLK);
    check("s5_post_mem_read", 32'(MEM_READ), 32'd0);
    check("s5_post_busywait", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK); #1;
    sb_q.push_back(8'h22);
    access(1'b1, 1'b0, 8'h05, 8'h00, cyc);
    check("s5_remiss_cycles", 32'(cyc), 32'd7);

    // 6: READ+WRITE together acts as a store.
    sb_q.push_back(8'h00);
    access(1'b1, 1'b1, 8'h05, 8'h5A, cyc);
    check("s6_hit_cycles", 32'(cyc), 32'd0);
    sb_q.push_back(8'h5A);
    access(1'b1, 1'b0, 8'h05, 8'h00, cyc);
    wb = wb_addr_log.size();
    m = mem_init(9);
    sb_q.push_back(m[15:8]);
    access(1'b1, 1'b0, 8'h25, 8'h00, cyc);
    check("s6_evict_cycles", 32'(cyc), 32'd12);
    if (wb_addr_log.size() > wb) begin
      check("s6_wb_addr", 32'(wb_addr_log[wb]), 32'h01);
      check("s6_wb_data", wb_data_log[wb], 32'h44AB5A11);
    end else check("s6_wb_count", 32'(wb_addr_log.size() - wb), 32'd1);

    check("dual_strobe_cycles", 32'(both_cnt), 32'd0);
    check("stray_writedata", 32'(stray_wd), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU's load/store path and the 32-bit-block data memory.
- Load data from this block feeds the register-file write port through the writeback mux, so it sits directly upstream of the register file.
- Stalls the CPU via BUSYWAIT on a miss; a hit completes in the request cycle.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- NUM_BLOCKS, 8, cache lines; power of two; index width = log2(NUM_BLOCKS) = 3.
- BLOCK_BYTES, 4, bytes per line; offset width = 2; tag width = ADDR_W-3-2 = 3.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high.
- READ  in  1  CPU load request; level, held until BUSYWAIT low.
- WRITE  in  1  CPU store request; level, held until BUSYWAIT low.
- ADDRESS  in  8  CPU byte address {tag[7:5], index[4:2], offset[1:0]}.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory block-read strobe.
- MEM_WRITE  out  1  memory block-write strobe.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  evicted block; byte0 = bits[7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; high in the same cycle a strobe rises, low when data is done/accepted.

Behaviour:
- Storage per line: valid, dirty, tag[2:0], data[31:0].
- Reset (RESET high at posedge):
  - clear all valid and dirty bits; state=IDLE; data/tag contents don't-care.
  - While RESET is high: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0.
- hit = valid[index] && tag[index]==ADDRESS tag; req = READ|WRITE.
- READ and WRITE both high is illegal and is treated as WRITE.
- States:
  - IDLE
    - req && hit: BUSYWAIT=0 combinationally.
      - Read: READDATA = selected byte of the line, combinational, same cycle.
      - Write: byte written and dirty set at the next posedge; stays IDLE.
    - req && !hit && !dirty[index] -> MEM_RD.
    - req && !hit && dirty[index] -> MEM_WB.
    - No req -> stay IDLE.
  - MEM_WB: MEM_WRITE=1; MEM_ADDRESS={stored tag,index}; MEM_WRITEDATA=line data.
    - Posedge with MEM_BUSYWAIT=0 -> MEM_RD.
  - MEM_RD: MEM_READ=1; MEM_ADDRESS={ADDRESS tag,index}.
    - Posedge with MEM_BUSYWAIT=0 -> UPDATE.
    - That posedge latches MEM_READDATA into an internal fill register.
  - UPDATE: line data=fill, tag=request tag, valid=1, dirty=0 at posedge -> IDLE.
    - The request then hits in IDLE: a read returns data; a write merges the byte and sets dirty.
- Outputs:
  - BUSYWAIT=1 in MEM_WB, MEM_RD and UPDATE, and in IDLE while req && !hit.
  - Strobes decode from state; at most one strobe is high in any cycle.
  - READDATA=8'h00 when READ is low or on a miss.
  - MEM_WRITEDATA=0 outside MEM_WB.
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss: 1 (IDLE detect) + memory cycles + 1 (UPDATE) + hit cycle.
  - Dirty miss: additionally the memory write cycles.
- Request rules:
  - The CPU must hold ADDRESS/WRITEDATA stable while BUSYWAIT=1; changes mid-miss are unsupported.
  - req dropping mid-miss does not abort the fill; the FSM completes to IDLE.
- RESET mid-miss: state goes to IDLE at that posedge; strobes fall; the partial fill is discarded; all lines are invalid.
- No # delays anywhere; all state updates are synchronous.

Decomposition:
- Shared package cpu_pkg:
  - state enum {IDLE, MEM_WB, MEM_RD, UPDATE}.
  - field widths TAG_W=3, IDX_W=3, OFF_W=2, BLOCK_W=32.
  - field-extract functions for tag, index and offset.
- One sub-module, dcache_array: tag/valid/dirty/data storage with combinational read and synchronous write/fill/reset. The FSM and output decode stay in dcache_ctrl.

Test Plan:
1. Reset, then READ addr 0x05; memory model has 4-cycle busy, block 0x01 = 0x44332211 -> MEM_READ on MEM_ADDRESS=0x01; BUSYWAIT high through UPDATE; READDATA=0x22; BUSYWAIT falls; repeat read of 0x05 hits with BUSYWAIT never high.
2. WRITE 0xAB to 0x06 after scenario 1 -> hit, no strobes; line 1 = 0x44AB2211 with dirty=1; READ 0x06 -> 0xAB in the same cycle.
3. Then READ 0x26 (tag 1, index 1, dirty conflict) -> MEM_WRITE first with MEM_ADDRESS=0x01, MEM_WRITEDATA=0x44AB2211; then MEM_READ with MEM_ADDRESS=0x09; never both strobes high; READDATA = byte2 of block 0x09.
4. WRITE to a cold line (addr 0x1C, data 0x7F) -> clean miss fill, then byte merge; dirty=1; no MEM_WRITE issued.
5. Assert RESET during the 2nd cycle of a MEM_RD -> next cycle MEM_READ=0, BUSYWAIT=0; READ 0x05 misses again.
6. READ and WRITE both high at addr 0x05 hit -> behaves as a write (line updated, dirty set); READDATA=0x00.
